// File: rtl/tmr_vote_controller.sv
// rtl/tmr_vote_controller.sv - 2-of-3 majority vote sequencer for three replica channels
// Collects one word per channel, votes or times out to a partial decision, holds result until accepted.
module tmr_vote_controller #(
  parameter int WIDTH    = 8,
  parameter int TIMEOUT  = 15,
  parameter int ERRCNT_W = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [2:0]          in_valid,
  output logic [2:0]          in_ready,
  input  logic [WIDTH-1:0]    in_data_a,
  input  logic [WIDTH-1:0]    in_data_b,
  input  logic [WIDTH-1:0]    in_data_c,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic                mismatch,
  output logic                degraded,
  output logic                fail,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_COLLECT, S_VOTE, S_OUTPUT} state_t;

  state_t              state_q, state_d;
  logic [2:0]          got_q, got_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [WIDTH-1:0]    a_q, a_d, b_q, b_d, c_q, c_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic                mismatch_q, mismatch_d;
  logic                degraded_q, degraded_d;
  logic                fail_q, fail_d;
  logic [ERRCNT_W-1:0] err_q, err_d;

  logic [2:0]          ready_c;
  logic [2:0]          cap;
  logic [WIDTH-1:0]    maj;
  logic                pair_ok;
  logic [WIDTH-1:0]    pair_word;

  assign maj = (a_q & b_q) | (b_q & c_q) | (a_q & c_q);

  // Exactly two captured channels that agree give a degraded result.
  always_comb begin
    pair_ok   = 1'b0;
    pair_word = '0;
    case (got_q)
      3'b011:  begin pair_ok = (a_q == b_q); pair_word = a_q; end
      3'b101:  begin pair_ok = (a_q == c_q); pair_word = a_q; end
      3'b110:  begin pair_ok = (b_q == c_q); pair_word = b_q; end
      default: begin pair_ok = 1'b0;         pair_word = '0;  end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    got_d      = got_q;
    timer_d    = timer_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    out_data_d = out_data_q;
    mismatch_d = mismatch_q;
    degraded_d = degraded_q;
    fail_d     = fail_q;
    err_d      = err_q;
    ready_c    = 3'b000;
    cap        = 3'b000;

    case (state_q)
      S_COLLECT: begin
        ready_c = ~got_q;
        cap     = in_valid & ~got_q;
        if (cap[0]) a_d = in_data_a;
        if (cap[1]) b_d = in_data_b;
        if (cap[2]) c_d = in_data_c;
        got_d = got_q | cap;
        if (got_q != 3'b000) timer_d = timer_q + TW'(1);
        else                 timer_d = '0;
        // The timeout edge lands exactly TIMEOUT edges after the first capture.
        if (got_d == 3'b111 || (got_q != 3'b000 && timer_d == TW'(TIMEOUT)))
          state_d = S_VOTE;
      end
      S_VOTE: begin
        mismatch_d = 1'b0;
        degraded_d = 1'b0;
        fail_d     = 1'b0;
        if (got_q == 3'b111) begin
          out_data_d = maj;
          mismatch_d = (a_q != maj) || (b_q != maj) || (c_q != maj);
        end else if (pair_ok) begin
          out_data_d = pair_word;
          degraded_d = 1'b1;
        end else begin
          out_data_d = '0;
          fail_d     = 1'b1;
        end
        if ((mismatch_d || degraded_d || fail_d) && (err_q != {ERRCNT_W{1'b1}}))
          err_d = err_q + ERRCNT_W'(1);
        state_d = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (out_ready) begin
          mismatch_d = 1'b0;
          degraded_d = 1'b0;
          fail_d     = 1'b0;
          got_d      = 3'b000;
          timer_d    = '0;
          state_d    = S_COLLECT;
        end
      end
      default: state_d = S_COLLECT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_COLLECT;
      got_q      <= 3'b000;
      timer_q    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      out_data_q <= '0;
      mismatch_q <= 1'b0;
      degraded_q <= 1'b0;
      fail_q     <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      got_q      <= got_d;
      timer_q    <= timer_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      out_data_q <= out_data_d;
      mismatch_q <= mismatch_d;
      degraded_q <= degraded_d;
      fail_q     <= fail_d;
      err_q      <= err_d;
    end
  end

  // No channel is offered ready while reset is held.
  assign in_ready  = reset ? 3'b000 : ready_c;
  assign out_valid = (state_q == S_OUTPUT);
  assign out_data  = out_data_q;
  assign mismatch  = mismatch_q;
  assign degraded  = degraded_q;
  assign fail      = fail_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_tmr_vote_controller.sv
// tb/tb_tmr_vote_controller.sv - directed vector bench for tmr_vote_controller
// Table of single transactions plus hand sequences for hold, reset, late capture and saturation.
module tb_tmr_vote_controller;

  localparam int TO = 15;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] in_valid;
  logic [2:0] in_ready;
  logic [7:0] in_data_a, in_data_b, in_data_c;
  logic       out_valid, out_ready;
  logic [7:0] out_data;
  logic       mismatch, degraded, fail;
  logic [7:0] err_count;

  tmr_vote_controller #(.WIDTH(8), .TIMEOUT(TO), .ERRCNT_W(8)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data_a(in_data_a), .in_data_b(in_data_b), .in_data_c(in_data_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .mismatch(mismatch), .degraded(degraded), .fail(fail), .err_count(err_count)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int exp_err = 0;

  typedef struct {
    logic [2:0] mask;
    logic [7:0] a, b, c;
    logic [7:0] d;
    logic       mm, dg, fl;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic wait_valid(inout int n);
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic bump_err(input logic any);
    if (any && exp_err < 255) exp_err++;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    in_valid  = v.mask;
    in_data_a = v.a;
    in_data_b = v.b;
    in_data_c = v.c;
    out_ready = 1'b1;
    tick();
    in_valid = 3'b000;
    n = 1;
    wait_valid(n);
    bump_err(v.mm | v.dg | v.fl);
    check($sformatf("v%0d latency", idx), n, (v.mask == 3'b111) ? 2 : TO + 2);
    check($sformatf("v%0d data", idx), out_data, v.d);
    check($sformatf("v%0d flags", idx), {mismatch, degraded, fail}, {v.mm, v.dg, v.fl});
    check($sformatf("v%0d err_count", idx), err_count, exp_err);
    tick();
    check($sformatf("v%0d release", idx), {out_valid, in_ready, mismatch, degraded, fail},
          {1'b0, 3'b111, 3'b000});
  endtask

  initial begin
    int n;
    vecs[0] = '{3'b111, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{3'b111, 8'hF0, 8'hFF, 8'h0F, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{3'b011, 8'h3C, 8'h3C, 8'h00, 8'h3C, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{3'b001, 8'h11, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{3'b011, 8'h11, 8'h22, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{3'b101, 8'h5A, 8'h00, 8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{3'b110, 8'h00, 8'h77, 8'h77, 8'h77, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{3'b111, 8'h12, 8'h34, 8'h12, 8'h12, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{3'b111, 8'h00, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0};

    reset     = 1'b1;
    in_valid  = 3'b000;
    in_data_a = 8'h00;
    in_data_b = 8'h00;
    in_data_c = 8'h00;
    out_ready = 1'b1;
    tick();
    check("reset outputs", {in_ready, out_valid, out_data, mismatch, degraded, fail, err_count},
          {3'b000, 1'b0, 8'h00, 3'b000, 8'h00});
    reset = 1'b0;
    tick();
    check("post-reset ready", {in_ready, out_valid}, {3'b111, 1'b0});

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Output held while downstream stalls; new words are refused until acceptance.
    in_valid  = 3'b111;
    in_data_a = 8'h81; in_data_b = 8'h81; in_data_c = 8'h81;
    out_ready = 1'b0;
    tick();
    in_data_a = 8'h24; in_data_b = 8'h24; in_data_c = 8'h24;
    check("vote ready", {in_ready, out_valid}, {3'b000, 1'b0});
    tick();
    for (int k = 0; k < 10; k++)
      check($sformatf("hold c%0d", k), {out_valid, in_ready, out_data, mismatch, degraded, fail},
            {1'b1, 3'b000, 8'h81, 3'b000});
      // fall through: the tick below advances the stall cycles
    for (int k = 0; k < 9; k++) begin
      tick();
      check($sformatf("hold stable %0d", k), {out_valid, in_ready, out_data}, {1'b1, 3'b000, 8'h81});
    end
    out_ready = 1'b1;
    tick();
    check("stall release", {out_valid, in_ready}, {1'b0, 3'b111});
    tick();
    in_valid = 3'b000;
    n = 1;
    wait_valid(n);
    check("held words latency", n, 2);
    check("held words result", {out_data, mismatch, degraded, fail}, {8'h24, 3'b000});
    tick();

    // Third replica captured exactly on the timeout edge still yields a full vote.
    in_valid  = 3'b011;
    in_data_a = 8'h66; in_data_b = 8'h66; in_data_c = 8'h67;
    tick();
    in_valid = 3'b000;
    for (int k = 0; k < TO - 1; k++) tick();
    check("late ready", {in_ready, out_valid}, {3'b100, 1'b0});
    in_valid = 3'b100;
    tick();
    in_valid = 3'b000;
    check("late in vote", out_valid, 1'b0);
    tick();
    bump_err(1'b1);
    check("late full vote", {out_valid, out_data, mismatch, degraded, fail},
          {1'b1, 8'h66, 3'b100});
    check("late err_count", err_count, exp_err);
    tick();

    // Reset mid-collect discards captured words and the error count.
    in_valid  = 3'b011;
    in_data_a = 8'h11; in_data_b = 8'h11;
    tick();
    in_valid = 3'b000;
    check("partial ready", in_ready, 3'b100);
    tick();
    reset = 1'b1;
    #1;
    check("mid reset outputs", {in_ready, out_valid, out_data, mismatch, degraded, fail, err_count},
          {3'b000, 1'b0, 8'h00, 3'b000, 8'h00});
    exp_err = 0;
    tick();
    reset = 1'b0;
    tick();
    check("reset cleared got", in_ready, 3'b111);
    begin
      vec_t v;
      v = '{3'b111, 8'hC3, 8'hC3, 8'h81, 8'hC3, 1'b1, 1'b0, 1'b0};
      run_vec(v, 9);
    end

    // Saturation of the error counter.
    in_data_a = 8'hF0; in_data_b = 8'hFF; in_data_c = 8'h0F;
    out_ready = 1'b1;
    for (int t = 0; t < 260; t++) begin
      in_valid = 3'b111;
      tick();
      in_valid = 3'b000;
      n = 1;
      wait_valid(n);
      bump_err(1'b1);
      if (exp_err == 254) check("err_count 254", err_count, 8'hFE);
      tick();
    end
    check("err_count saturated", err_count, 8'hFF);
    check("err_count exp", exp_err, 255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
